// File: rtl/esp_bus_master_pkg.sv
// esp_bus_master_pkg
//   Shared encodings for the Z80 bus master and the SPI command decoder:
//   command opcodes, bus-master FSM states and a small elaboration helper.
package esp_bus_master_pkg;

  typedef enum logic [1:0] {
    OP_ACQUIRE = 2'd0,
    OP_RELEASE = 2'd1,
    OP_WRITE   = 2'd2,
    OP_READ    = 2'd3
  } cmd_op_e;

  typedef enum logic [2:0] {
    ST_FREE,
    ST_REQ,
    ST_OWNED,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_RESP
  } bus_state_e;

  // Larger of two ints, used to size the shared cycle counter.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/esp_bus_master_sync2.sv
// sync2
//   Two-flop synchronizer for a single asynchronous input.
//   i_clk    destination clock
//   i_rst_n  asynchronous active-low reset (both flops load RST_VAL)
//   i_d      asynchronous input
//   o_q      synchronized output (two cycles of latency)
module sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/esp_bus_master.sv
// esp_bus_master
//   Acquires/releases the Z80 external bus (busreq_n/busack_n) and runs
//   memory read/write cycles with programmable setup/strobe/hold timing on
//   behalf of the SPI command decoder.
// Ports:
//   clk, reset_n                 sysclk, async active-low reset
//   cmd_valid/cmd_ready/cmd_op   command handshake and opcode
//   cmd_addr/cmd_wrdata          address and write data for WRITE/READ
//   rsp_valid/rsp_err            one-cycle completion pulse and error flag
//   rsp_rddata                   last read data
//   owned                        bus currently owned
//   ebus_busreq_n/ebus_busack_n  Z80 bus request / acknowledge (async)
//   ebus_oe, ebus_d_oe           pin driver enables (addr+strobes, data)
//   ebus_a_out/d_out/d_in        address, write data, read data
//   ebus_rd_n/wr_n/mreq_n        Z80 memory strobes
module esp_bus_master
  import esp_bus_master_pkg::*;
#(
  parameter int SETUP_CYC   = 3,
  parameter int STROBE_CYC  = 6,
  parameter int HOLD_CYC    = 2,
  parameter int ACK_TIMEOUT = 4095
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [15:0] cmd_addr,
  input  logic [7:0]  cmd_wrdata,
  output logic        rsp_valid,
  output logic        rsp_err,
  output logic [7:0]  rsp_rddata,
  output logic        owned,
  output logic        ebus_busreq_n,
  input  logic        ebus_busack_n,
  output logic        ebus_oe,
  output logic [15:0] ebus_a_out,
  output logic [7:0]  ebus_d_out,
  output logic        ebus_d_oe,
  input  logic [7:0]  ebus_d_in,
  output logic        ebus_rd_n,
  output logic        ebus_wr_n,
  output logic        ebus_mreq_n
);

  localparam int MAXP = max_int(max_int(SETUP_CYC, STROBE_CYC),
                                max_int(HOLD_CYC, ACK_TIMEOUT));
  localparam int CW   = $clog2(MAXP + 1);

  logic w_ack_n;
  logic w_abort;

  bus_state_e    r_state;
  logic [CW-1:0] r_cnt;
  logic          r_is_wr;
  logic          r_cmd_ready;
  logic          r_rsp_valid;
  logic          r_rsp_err;
  logic [7:0]    r_rsp_rddata;
  logic          r_owned;
  logic          r_busreq_n;
  logic          r_oe;
  logic [15:0]   r_a_out;
  logic [7:0]    r_d_out;
  logic          r_d_oe;
  logic          r_rd_n;
  logic          r_wr_n;
  logic          r_mreq_n;

  sync2 #(.RST_VAL(1'b1)) u_ack_sync (
    .i_clk   (clk),
    .i_rst_n (reset_n),
    .i_d     (ebus_busack_n),
    .o_q     (w_ack_n)
  );

  // Z80 took the bus back while a memory cycle was in flight.
  assign w_abort = w_ack_n && (r_state == ST_SETUP || r_state == ST_STROBE ||
                               r_state == ST_HOLD);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_FREE;
      r_cnt        <= '0;
      r_is_wr      <= 1'b0;
      r_cmd_ready  <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp_err    <= 1'b0;
      r_rsp_rddata <= '0;
      r_owned      <= 1'b0;
      r_busreq_n   <= 1'b1;
      r_oe         <= 1'b0;
      r_a_out      <= '0;
      r_d_out      <= '0;
      r_d_oe       <= 1'b0;
      r_rd_n       <= 1'b1;
      r_wr_n       <= 1'b1;
      r_mreq_n     <= 1'b1;
    end else begin
      // Counter free-runs within a state; every transition reloads it.
      r_rsp_valid <= 1'b0;
      r_cnt       <= r_cnt + 1'b1;
      if (w_abort) begin
        r_cnt       <= '0;
        r_rd_n      <= 1'b1;
        r_wr_n      <= 1'b1;
        r_mreq_n    <= 1'b1;
        r_oe        <= 1'b0;
        r_d_oe      <= 1'b0;
        r_owned     <= 1'b0;
        r_busreq_n  <= 1'b1;
        r_rsp_valid <= 1'b1;
        r_rsp_err   <= 1'b1;
        r_state     <= ST_RESP;
      end else begin
        case (r_state)
          ST_FREE: begin
            r_cmd_ready <= 1'b1;
            if (cmd_valid && r_cmd_ready) begin
              r_cmd_ready <= 1'b0;
              r_cnt       <= '0;
              case (cmd_op_e'(cmd_op))
                OP_ACQUIRE: begin
                  r_busreq_n <= 1'b0;
                  r_state    <= ST_REQ;
                end
                OP_RELEASE: begin
                  r_rsp_valid <= 1'b1;
                  r_rsp_err   <= 1'b0;
                  r_state     <= ST_RESP;
                end
                default: begin
                  // Memory cycle without the bus: refuse, touch nothing.
                  r_rsp_valid <= 1'b1;
                  r_rsp_err   <= 1'b1;
                  r_state     <= ST_RESP;
                end
              endcase
            end
          end
          ST_REQ: begin
            if (!w_ack_n) begin
              r_cnt       <= '0;
              r_owned     <= 1'b1;
              r_oe        <= 1'b1;
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b0;
              r_state     <= ST_RESP;
            end else if (r_cnt == CW'(ACK_TIMEOUT - 1)) begin
              r_cnt       <= '0;
              r_busreq_n  <= 1'b1;
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b1;
              r_state     <= ST_RESP;
            end
          end
          ST_OWNED: begin
            r_cmd_ready <= 1'b1;
            if (cmd_valid && r_cmd_ready) begin
              r_cmd_ready <= 1'b0;
              r_cnt       <= '0;
              case (cmd_op_e'(cmd_op))
                OP_ACQUIRE: begin
                  r_rsp_valid <= 1'b1;
                  r_rsp_err   <= 1'b0;
                  r_state     <= ST_RESP;
                end
                OP_RELEASE: begin
                  // Release without waiting for busack_n to rise.
                  r_oe        <= 1'b0;
                  r_d_oe      <= 1'b0;
                  r_busreq_n  <= 1'b1;
                  r_owned     <= 1'b0;
                  r_rsp_valid <= 1'b1;
                  r_rsp_err   <= 1'b0;
                  r_state     <= ST_RESP;
                end
                default: begin
                  r_a_out <= cmd_addr;
                  r_d_out <= cmd_wrdata;
                  r_is_wr <= (cmd_op_e'(cmd_op) == OP_WRITE);
                  r_d_oe  <= (cmd_op_e'(cmd_op) == OP_WRITE);
                  r_state <= ST_SETUP;
                end
              endcase
            end
          end
          ST_SETUP: begin
            if (r_cnt == CW'(SETUP_CYC - 1)) begin
              r_cnt    <= '0;
              r_mreq_n <= 1'b0;
              r_wr_n   <= !r_is_wr;
              r_rd_n   <= r_is_wr;
              r_state  <= ST_STROBE;
            end
          end
          ST_STROBE: begin
            if (r_cnt == CW'(STROBE_CYC - 1)) begin
              r_cnt    <= '0;
              r_mreq_n <= 1'b1;
              r_wr_n   <= 1'b1;
              r_rd_n   <= 1'b1;
              if (!r_is_wr) r_rsp_rddata <= ebus_d_in;
              r_state  <= ST_HOLD;
            end
          end
          ST_HOLD: begin
            if (r_cnt == CW'(HOLD_CYC - 1)) begin
              r_cnt       <= '0;
              r_d_oe      <= 1'b0;
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b0;
              r_state     <= ST_RESP;
            end
          end
          ST_RESP: begin
            r_cnt       <= '0;
            r_cmd_ready <= 1'b1;
            r_state     <= r_owned ? ST_OWNED : ST_FREE;
          end
          default: begin
            r_cnt   <= '0;
            r_state <= ST_FREE;
          end
        endcase
      end
    end
  end

  assign cmd_ready     = r_cmd_ready;
  assign rsp_valid     = r_rsp_valid;
  assign rsp_err       = r_rsp_err;
  assign rsp_rddata    = r_rsp_rddata;
  assign owned         = r_owned;
  assign ebus_busreq_n = r_busreq_n;
  assign ebus_oe       = r_oe;
  assign ebus_a_out    = r_a_out;
  assign ebus_d_out    = r_d_out;
  assign ebus_d_oe     = r_d_oe;
  assign ebus_rd_n     = r_rd_n;
  assign ebus_wr_n     = r_wr_n;
  assign ebus_mreq_n   = r_mreq_n;

endmodule

// File: tb/tb_esp_bus_master.sv
// tb_esp_bus_master
//   Directed bench for esp_bus_master with default timing parameters.
//   A tiny Z80 model echoes busreq_n onto busack_n two clocks later;
//   force_hi overrides it to model a refused or withdrawn bus grant.
module tb_esp_bus_master;
  import esp_bus_master_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid;
  logic [1:0]  cmd_op;
  logic [15:0] cmd_addr;
  logic [7:0]  cmd_wrdata;
  logic [7:0]  d_in;
  logic        cmd_ready, rsp_valid, rsp_err, owned;
  logic [7:0]  rsp_rddata;
  logic        busreq_n, busack_n, oe, d_oe, rd_n, wr_n, mreq_n;
  logic [15:0] a_out;
  logic [7:0]  d_out;

  logic z1 = 1'b1, z80_ack_n = 1'b1, force_hi = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  // {ready,valid,err,rddata,owned,busreq_n,oe,d_oe,a,d,rd_n,wr_n,mreq_n}
  localparam logic [41:0] RST_VEC = {1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1,
                                     1'b0, 1'b0, 16'h0000, 8'h00,
                                     1'b1, 1'b1, 1'b1};

  always #5 clk = ~clk;

  always @(posedge clk) begin
    z1        <= busreq_n;
    z80_ack_n <= z1;
  end
  assign busack_n = z80_ack_n | force_hi;

  esp_bus_master dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_op        (cmd_op),
    .cmd_addr      (cmd_addr),
    .cmd_wrdata    (cmd_wrdata),
    .rsp_valid     (rsp_valid),
    .rsp_err       (rsp_err),
    .rsp_rddata    (rsp_rddata),
    .owned         (owned),
    .ebus_busreq_n (busreq_n),
    .ebus_busack_n (busack_n),
    .ebus_oe       (oe),
    .ebus_a_out    (a_out),
    .ebus_d_out    (d_out),
    .ebus_d_oe     (d_oe),
    .ebus_d_in     (d_in),
    .ebus_rd_n     (rd_n),
    .ebus_wr_n     (wr_n),
    .ebus_mreq_n   (mreq_n)
  );

  function automatic logic [41:0] snap();
    return {cmd_ready, rsp_valid, rsp_err, rsp_rddata, owned, busreq_n, oe,
            d_oe, a_out, d_out, rd_n, wr_n, mreq_n};
  endfunction

  // Presents one command; returns at the first negedge after the accepting
  // edge (that sample is cycle 1 after accept).
  task automatic send(input cmd_op_e op, input logic [15:0] addr,
                      input logic [7:0] data, output bit ok);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_wrdata = data;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (cmd_ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_addr = '0;
    cmd_wrdata = '0; d_in = 8'hFF;
    repeat (3) @(negedge clk);
    n_vec++;
    if (snap() !== RST_VEC) begin
      n_err++; $display("FAIL reset_values: got %h want %h", snap(), RST_VEC);
    end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    n_vec++;
    if (cmd_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_ready: got %b want 1", cmd_ready);
    end
  endtask

  task automatic test_free_cmds();
    bit ok; bit bad; int n;
    send(OP_WRITE, 16'h1111, 8'h99, ok);
    n = 1; bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (!rd_n || !wr_n || !mreq_n || oe || d_oe || !busreq_n) bad = 1'b1;
      if (rsp_valid) break;
      @(negedge clk); n++;
    end
    n_vec++;
    if (!ok || n != 1 || rsp_valid !== 1'b1 || rsp_err !== 1'b1) begin
      n_err++; $display("FAIL free_write_rsp: ok=%b n=%0d v=%b err=%b want n=1 err=1",
                        ok, n, rsp_valid, rsp_err);
    end
    repeat (3) begin
      @(negedge clk);
      if (!rd_n || !wr_n || !mreq_n || oe || d_oe || !busreq_n) bad = 1'b1;
    end
    n_vec++;
    if (bad) begin
      n_err++; $display("FAIL free_write_quiet: bus activity got 1 want 0");
    end
    send(OP_RELEASE, 16'h0, 8'h0, ok);
    n_vec++;
    if (!ok || rsp_valid !== 1'b1 || rsp_err !== 1'b0 || owned !== 1'b0) begin
      n_err++; $display("FAIL free_release: ok=%b v=%b err=%b owned=%b want 1/0/0",
                        ok, rsp_valid, rsp_err, owned);
    end
  endtask

  task automatic test_acquire();
    bit ok; int n;
    send(OP_ACQUIRE, 16'h0, 8'h0, ok);
    n = 1;
    while (!rsp_valid && n < 30) begin @(negedge clk); n++; end
    n_vec++;
    if (!ok || rsp_valid !== 1'b1 || rsp_err !== 1'b0) begin
      n_err++; $display("FAIL acquire_rsp: ok=%b v=%b err=%b want v=1 err=0",
                        ok, rsp_valid, rsp_err);
    end
    n_vec++;
    if (owned !== 1'b1 || oe !== 1'b1 || busreq_n !== 1'b0) begin
      n_err++; $display("FAIL acquire_state: owned=%b oe=%b busreq_n=%b want 1/1/0",
                        owned, oe, busreq_n);
    end
  endtask

  task automatic test_write();
    bit ok; bit bad; int n, pre, st;
    send(OP_WRITE, 16'h8000, 8'h42, ok);
    n = 1; pre = 0; st = 0; bad = 1'b0;
    while (!rsp_valid && n < 40) begin
      if (wr_n !== mreq_n || !rd_n) bad = 1'b1;
      if (!wr_n) begin
        st++;
        if (!d_oe || d_out !== 8'h42 || a_out !== 16'h8000) bad = 1'b1;
      end else if (st == 0 && a_out === 16'h8000) pre++;
      @(negedge clk); n++;
    end
    n_vec++;
    if (pre != 3) begin n_err++; $display("FAIL write_setup: got %0d want 3", pre); end
    n_vec++;
    if (st != 6) begin n_err++; $display("FAIL write_strobe: got %0d want 6", st); end
    n_vec++;
    if (bad) begin n_err++; $display("FAIL write_drive: bad bus values during cycle"); end
    n_vec++;
    if (!ok || n != 12 || rsp_err !== 1'b0 || d_oe !== 1'b0) begin
      n_err++; $display("FAIL write_latency: ok=%b n=%0d err=%b d_oe=%b want n=12 err=0 d_oe=0",
                        ok, n, rsp_err, d_oe);
    end
  endtask

  task automatic test_read();
    bit ok; bit bad; int n, st;
    send(OP_READ, 16'h3000, 8'h00, ok);
    n = 1; st = 0; bad = 1'b0;
    while (!rsp_valid && n < 40) begin
      d_in = (!rd_n) ? 8'h5A : 8'hFF;
      if (rd_n !== mreq_n || !wr_n || d_oe) bad = 1'b1;
      if (!rd_n) begin st++; if (a_out !== 16'h3000) bad = 1'b1; end
      @(negedge clk); n++;
    end
    d_in = 8'hFF;
    n_vec++;
    if (st != 6 || bad) begin
      n_err++; $display("FAIL read_strobe: cycles=%0d bad=%b want 6 bad=0", st, bad);
    end
    n_vec++;
    if (!ok || n != 12 || rsp_err !== 1'b0 || rsp_rddata !== 8'h5A) begin
      n_err++; $display("FAIL read_rsp: ok=%b n=%0d err=%b data=%h want n=12 err=0 data=5a",
                        ok, n, rsp_err, rsp_rddata);
    end
  endtask

  task automatic test_back_to_back();
    bit ok; int n;
    send(OP_WRITE, 16'h1234, 8'hA5, ok);
    n = 1;
    while (!rsp_valid && n < 40) begin @(negedge clk); n++; end
    @(negedge clk);
    n_vec++;
    if (cmd_ready !== 1'b1 || owned !== 1'b1) begin
      n_err++; $display("FAIL b2b_ready: ready=%b owned=%b want 1/1", cmd_ready, owned);
    end
    send(OP_ACQUIRE, 16'h0, 8'h0, ok);
    n_vec++;
    if (!ok || rsp_valid !== 1'b1 || rsp_err !== 1'b0 || owned !== 1'b1) begin
      n_err++; $display("FAIL b2b_reacquire: ok=%b v=%b err=%b owned=%b want 1/0/1",
                        ok, rsp_valid, rsp_err, owned);
    end
    send(OP_RELEASE, 16'h0, 8'h0, ok);
    n_vec++;
    if (!ok || rsp_valid !== 1'b1 || rsp_err !== 1'b0 || owned !== 1'b0 ||
        oe !== 1'b0 || busreq_n !== 1'b1) begin
      n_err++; $display("FAIL b2b_release: v=%b err=%b owned=%b oe=%b busreq_n=%b want 1/0/0/0/1",
                        rsp_valid, rsp_err, owned, oe, busreq_n);
    end
  endtask

  task automatic test_loss();
    bit ok; int n, st;
    repeat (8) @(negedge clk);
    send(OP_ACQUIRE, 16'h0, 8'h0, ok);
    n = 1;
    while (!rsp_valid && n < 30) begin @(negedge clk); n++; end
    send(OP_WRITE, 16'h4000, 8'h11, ok);
    n = 1; st = 0;
    while (!rsp_valid && n < 40) begin
      if (!wr_n) st++;
      if (st == 3) force_hi = 1'b1;
      @(negedge clk); n++;
    end
    // ack withdrawn at cycle 6; 2 sync flops + 1 reaction edge -> rsp at 9
    n_vec++;
    if (!ok || n != 9 || st != 5 || rsp_err !== 1'b1) begin
      n_err++; $display("FAIL loss_timing: n=%0d strobe=%0d err=%b want 9/5/1", n, st, rsp_err);
    end
    n_vec++;
    if ({rd_n, wr_n, mreq_n, oe, d_oe, owned, busreq_n} !== 7'b1110001) begin
      n_err++; $display("FAIL loss_release: got %b want 1110001",
                        {rd_n, wr_n, mreq_n, oe, d_oe, owned, busreq_n});
    end
  endtask

  task automatic test_timeout();
    bit ok; int n, low;
    send(OP_ACQUIRE, 16'h0, 8'h0, ok);
    n = 1; low = 0;
    while (!rsp_valid && n < 5000) begin
      if (!busreq_n) low++;
      @(negedge clk); n++;
    end
    n_vec++;
    if (!ok || rsp_valid !== 1'b1 || rsp_err !== 1'b1 || low != 4095) begin
      n_err++; $display("FAIL timeout_rsp: v=%b err=%b req_cycles=%0d want 1/1/4095",
                        rsp_valid, rsp_err, low);
    end
    n_vec++;
    if (busreq_n !== 1'b1 || owned !== 1'b0 || oe !== 1'b0) begin
      n_err++; $display("FAIL timeout_state: busreq_n=%b owned=%b oe=%b want 1/0/0",
                        busreq_n, owned, oe);
    end
    force_hi = 1'b0;
  endtask

  task automatic test_reset_mid_write();
    bit ok; int n;
    repeat (8) @(negedge clk);
    send(OP_ACQUIRE, 16'h0, 8'h0, ok);
    n = 1;
    while (!rsp_valid && n < 30) begin @(negedge clk); n++; end
    send(OP_WRITE, 16'h2222, 8'h77, ok);
    n = 1;
    while (wr_n && n < 20) begin @(negedge clk); n++; end
    n_vec++;
    if (wr_n !== 1'b0) begin
      n_err++; $display("FAIL midrst_setup: wr_n got %b want 0", wr_n);
    end
    #2 reset_n = 1'b0;
    #1;
    n_vec++;
    if (snap() !== RST_VEC) begin
      n_err++; $display("FAIL midrst_async: got %h want %h", snap(), RST_VEC);
    end
    repeat (3) @(negedge clk);
    n_vec++;
    if (snap() !== RST_VEC) begin
      n_err++; $display("FAIL midrst_held: got %h want %h", snap(), RST_VEC);
    end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    n_vec++;
    if (cmd_ready !== 1'b1 || owned !== 1'b0 || rsp_valid !== 1'b0) begin
      n_err++; $display("FAIL midrst_after: ready=%b owned=%b v=%b want 1/0/0",
                        cmd_ready, owned, rsp_valid);
    end
  endtask

  initial begin
    test_reset();
    test_free_cmds();
    test_acquire();
    test_write();
    test_read();
    test_back_to_back();
    test_loss();
    test_timeout();
    test_reset_mid_write();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
